// File: rtl/decode_queue_if.sv
// Shared decoded-instruction types and the fetch/issue bus for decode_queue.
// The package lives beside the interface because both ports and storage use it.
package decode_queue_pkg;

   typedef enum logic [4:0] {
      OP_SLL, OP_SRL, OP_SRA, OP_JR, OP_ADDU, OP_SUBU, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW, OP_RESERVED
   } op_t;

   typedef struct packed {
      logic branch;
      logic jump;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic alu_imm;
   } ctl_t;

   // target: branch/jump destination, or pc+4 (link address) otherwise.
   typedef struct packed {
      op_t         op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [31:0] target;
      ctl_t        ctl;
      logic        exception_ri;
   } decoded_instr_t;

endpackage

// Handshakes on this bus:
//   fetch side: a bundle transfers on a clock edge where in_valid & in_ready & !flush;
//   in_valid may be held while in_ready is low and nothing is written.
//   issue side: out_valid is a prefix of lanes that may be taken this cycle;
//   out_accept lanes (oldest first) are consumed at the edge and never exceed the valid prefix.
interface decode_queue_if #(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
);
   localparam int DW = $bits(decode_queue_pkg::decoded_instr_t);

   logic                               flush;
   logic                               in_valid;
   logic                               in_ready;
   logic [FETCH_WIDTH-1:0]             in_mask;
   logic [FETCH_WIDTH*32-1:0]          in_instr;
   logic [FETCH_WIDTH*32-1:0]          in_pc;
   logic [ISSUE_WIDTH-1:0]             out_valid;
   logic [ISSUE_WIDTH*DW-1:0]          out_instr;
   logic [ISSUE_WIDTH*32-1:0]          out_pc;
   logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_accept;
   logic [$clog2(DEPTH+1)-1:0]         count;

   modport master (
      output flush, in_valid, in_mask, in_instr, in_pc, out_accept,
      input  in_ready, out_valid, out_instr, out_pc, count
   );

   modport slave (
      input  flush, in_valid, in_mask, in_instr, in_pc, out_accept,
      output in_ready, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane MIPS decode queue: decodes up to FETCH_WIDTH instructions per cycle
// into a circular buffer and presents up to ISSUE_WIDTH oldest entries to issue,
// never exposing a branch/jump without its delay slot in the same window.
// The interface instance must be built with the same three parameters.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input logic            clk,
   input logic            resetn,
   decode_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ACC_W = $clog2(ISSUE_WIDTH + 1);
   localparam int DW    = $bits(decoded_instr_t);

   decoded_instr_t           mem_instr [DEPTH];
   logic [31:0]              mem_pc    [DEPTH];
   logic [PTR_W-1:0]         head;
   logic [PTR_W-1:0]         tail;
   logic [CNT_W-1:0]         count_q;
   logic [CNT_W-1:0]         count_next;
   logic [CNT_W-1:0]         enq_cnt;
   logic [CNT_W-1:0]         free_slots;
   logic                     enq_fire;
   logic                     mask_contig;
   logic [FETCH_WIDTH:0]     mask_ext;
   decoded_instr_t           lane_dec  [FETCH_WIDTH];
   logic [ISSUE_WIDTH:0]     raw_v;
   logic [ISSUE_WIDTH-1:0]   issue_v;
   logic [ACC_W-1:0]         issue_cnt;
   logic                     hold;
   logic [PTR_W-1:0]         win_idx;

   // Single-instruction MIPS decoder; unknown opcodes/functs become OP_RESERVED with exception_ri.
   function automatic decoded_instr_t decode_mips(input logic [31:0] instr,
                                                  input logic [31:0] pcplus4);
      decoded_instr_t d;
      logic [31:0]    sext;
      logic [31:0]    zext;
      sext           = {{16{instr[15]}}, instr[15:0]};
      zext           = {16'h0000, instr[15:0]};
      d              = '0;
      d.op           = OP_RESERVED;
      d.rs           = instr[25:21];
      d.rt           = instr[20:16];
      d.rd           = instr[15:11];
      d.shamt        = instr[10:6];
      d.imm          = sext;
      d.target       = pcplus4;
      case (instr[31:26])
         6'h00: begin
            d.ctl.reg_write = 1'b1;
            case (instr[5:0])
               6'h00: d.op = OP_SLL;
               6'h02: d.op = OP_SRL;
               6'h03: d.op = OP_SRA;
               6'h08: begin
                  d.op            = OP_JR;
                  d.ctl.jump      = 1'b1;
                  d.ctl.reg_write = 1'b0;
               end
               6'h21: d.op = OP_ADDU;
               6'h23: d.op = OP_SUBU;
               6'h24: d.op = OP_AND;
               6'h25: d.op = OP_OR;
               6'h26: d.op = OP_XOR;
               6'h27: d.op = OP_NOR;
               6'h2A: d.op = OP_SLT;
               6'h2B: d.op = OP_SLTU;
               default: d.op = OP_RESERVED;
            endcase
         end
         6'h02: begin
            d.op       = OP_J;
            d.ctl.jump = 1'b1;
            d.target   = {pcplus4[31:28], instr[25:0], 2'b00};
         end
         6'h03: begin
            d.op            = OP_JAL;
            d.ctl.jump      = 1'b1;
            d.ctl.reg_write = 1'b1;
            d.rd            = 5'd31;
            d.target        = {pcplus4[31:28], instr[25:0], 2'b00};
         end
         6'h04, 6'h05: begin
            d.op         = (instr[26]) ? OP_BNE : OP_BEQ;
            d.ctl.branch = 1'b1;
            d.target     = pcplus4 + {sext[29:0], 2'b00};
         end
         6'h09: begin d.op = OP_ADDIU; d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; end
         6'h0A: begin d.op = OP_SLTI;  d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; end
         6'h0B: begin d.op = OP_SLTIU; d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; end
         6'h0C: begin d.op = OP_ANDI;  d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; d.imm = zext; end
         6'h0D: begin d.op = OP_ORI;   d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; d.imm = zext; end
         6'h0E: begin d.op = OP_XORI;  d.ctl.reg_write = 1'b1; d.ctl.alu_imm = 1'b1; d.imm = zext; end
         6'h0F: begin
            d.op            = OP_LUI;
            d.ctl.reg_write = 1'b1;
            d.ctl.alu_imm   = 1'b1;
            d.imm           = {instr[15:0], 16'h0000};
         end
         6'h23: begin
            d.op            = OP_LW;
            d.ctl.reg_write = 1'b1;
            d.ctl.mem_read  = 1'b1;
            d.ctl.alu_imm   = 1'b1;
         end
         6'h2B: begin
            d.op            = OP_SW;
            d.ctl.mem_write = 1'b1;
            d.ctl.alu_imm   = 1'b1;
         end
         default: d.op = OP_RESERVED;
      endcase
      if (d.op == OP_RESERVED) begin
         d.ctl          = '0;
         d.exception_ri = 1'b1;
      end
      return d;
   endfunction

   // One decoder per fetch lane, each fed with its own pc+4.
   always_comb begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
         lane_dec[l] = decode_mips(bus.in_instr[l*32 +: 32], bus.in_pc[l*32 +: 32] + 32'd4);
      end
   end

   // Enqueue control: readiness uses only the registered count, so same-cycle dequeues are not credited.
   always_comb begin
      enq_cnt = '0;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
         enq_cnt = enq_cnt + CNT_W'(bus.in_mask[l]);
      end
      mask_ext     = {1'b0, bus.in_mask};
      mask_contig  = ((mask_ext & (mask_ext + 1'b1)) == '0);
      free_slots   = CNT_W'(DEPTH) - count_q;
      bus.in_ready = resetn && (free_slots >= CNT_W'(FETCH_WIDTH));
      enq_fire     = bus.in_valid && bus.in_ready && !bus.flush;
      count_next   = count_q + (enq_fire ? enq_cnt : '0) - CNT_W'(bus.out_accept);
   end

   // Pointer and occupancy registers; flush overrides any enqueue or dequeue in the same cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (enq_fire) begin
            tail <= tail + PTR_W'(enq_cnt);
         end
         head    <= head + PTR_W'(bus.out_accept);
         count_q <= count_next;
      end
   end

   // Entry storage: lane l of a prefix-contiguous bundle lands at tail+l, wrapping naturally.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (bus.in_mask[l]) begin
               mem_instr[tail + PTR_W'(l)] <= lane_dec[l];
               mem_pc[tail + PTR_W'(l)]    <= bus.in_pc[l*32 +: 32];
            end
         end
      end
   end

   // Issue window: oldest entries in lane order, truncated at a branch whose delay slot is not yet visible.
   always_comb begin
      bus.out_instr = '0;
      bus.out_pc    = '0;
      raw_v         = '0;
      issue_v       = '0;
      issue_cnt     = '0;
      hold          = 1'b0;
      win_idx       = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         raw_v[i] = (CNT_W'(i) < count_q);
      end
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         win_idx                    = head + PTR_W'(i);
         bus.out_instr[i*DW +: DW]  = mem_instr[win_idx];
         bus.out_pc[i*32 +: 32]     = mem_pc[win_idx];
         // With a single issue lane the issue stage pairs branch and slot itself.
         if (ISSUE_WIDTH > 1 && raw_v[i] && !raw_v[i+1] &&
             (mem_instr[win_idx].ctl.branch || mem_instr[win_idx].ctl.jump)) begin
            hold = 1'b1;
         end
         issue_v[i] = raw_v[i] && !hold;
         issue_cnt  = issue_cnt + ACC_W'(issue_v[i]);
      end
      bus.out_valid = issue_v;
      bus.count     = count_q;
   end

   // Protocol and invariant checks.
   assert property (@(posedge clk) disable iff (!resetn) bus.in_valid |-> mask_contig);
   assert property (@(posedge clk) disable iff (!resetn) enq_fire |-> (enq_cnt <= free_slots));
   assert property (@(posedge clk) disable iff (!resetn) bus.out_accept <= issue_cnt);
   assert property (@(posedge clk) disable iff (!resetn) count_q <= CNT_W'(DEPTH));

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-instruction combinational decoder.
- Decodes a fetch bundle of up to FETCH_WIDTH MIPS instructions per cycle, one decoder per lane, and stores the results in a circular buffer of DEPTH entries.
- Presents up to ISSUE_WIDTH oldest decoded instructions per cycle to the issue stage.
- Keeps branch/jump instructions together with their delay slot and supports pipeline flush.

Parameters:
- FETCH_WIDTH, 2: lanes accepted per fetch bundle (1..4).
- ISSUE_WIDTH, 2: lanes presented to issue per cycle (1..4).
- DEPTH, 8: buffer entries. Power of two, ≥ 2*max(FETCH_WIDTH, ISSUE_WIDTH).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  fetch bundle present
- in_ready  out  1  buffer can accept a full bundle
- in_mask  in  FETCH_WIDTH  per-lane valid. Must be prefix-contiguous from lane 0.
- in_instr  in  FETCH_WIDTH*32  raw instructions, lane 0 in LSBs
- in_pc  in  FETCH_WIDTH*32  PC per lane
- out_valid  out  ISSUE_WIDTH  per-lane issue-valid, always prefix-contiguous
- out_instr  out  ISSUE_WIDTH*$bits(decoded_instr_t)  decoded instructions, oldest in lane 0
- out_pc  out  ISSUE_WIDTH*32  PC per issue lane
- out_accept  in  $clog2(ISSUE_WIDTH+1)  number of lanes consumed this cycle
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn=0 at a posedge):
  - head=0, tail=0, count=0.
  - out_valid=0.
  - in_ready=0 while resetn=0, and 1 in the first cycle after release.
- Decode on enqueue:
  - Each lane drives the standard decoder with pcplus4 = in_pc+4.
  - Stored entry = {decoded_instr_t, pc}. exception_ri is carried unchanged.
- in_ready = (DEPTH - count) ≥ FETCH_WIDTH.
  - Computed from registered count only; same-cycle dequeues are not credited.
- Enqueue fires when in_valid & in_ready & !flush.
  - popcount(in_mask) entries are written at tail..tail+n-1, modulo DEPTH.
  - tail advances by n.
  - in_mask=0 with in_valid=1 is legal and writes nothing.
- Issue window:
  - Lane i shows entry head+i (mod DEPTH) when i < count.
  - Raw valid: v[i] = (i < count).
- Delay-slot rule:
  - If entry in lane j has ctl.branch | ctl.jump, and lane j+1 is not raw-valid or j = ISSUE_WIDTH-1, then out_valid[j] and every higher lane are 0.
  - The branch stays at its position until its delay slot is visible in the same window.
  - ISSUE_WIDTH=1 is the exception: the rule is disabled, and the issue stage owns pairing.
- Dequeue:
  - out_accept ≤ popcount(out_valid) is required; violation is an assertion failure.
  - head advances by out_accept.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + n - out_accept.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. A bundle may straddle the DEPTH-1 → 0 boundary.
- Flush:
  - Takes priority over enqueue and dequeue in the same cycle: head=tail=0, count=0.
  - out_valid=0 the next cycle.
- Outputs are combinational from registered buffer state only. There is no in→out bypass: minimum latency from enqueue to out_valid is 1 cycle.
- Full: count=DEPTH gives in_ready=0, with no overwrite.
- Empty: out_valid=0; out_instr contents are don't-care.
- Assertions:
  - in_mask not prefix-contiguous.
  - Enqueue when !in_ready.
  - out_accept too large.
  - count > DEPTH.

Test Plan (defaults FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8):
- Basic flow:
  - Stimulus: after reset, bundle {0x24080005 addiu, 0x00000000 sll}, pc {0xBFC00000, 0xBFC00004}, mask=11.
  - Response: next cycle count=2, out_valid=11, lane0 op=ADDIU with imm=5, lane1 op=SLL, out_pc[0]=0xBFC00000. out_accept=2 → count=0, out_valid=00.
- Full/backpressure:
  - Stimulus: 4 bundles with out_accept=0.
  - Response: count=8, in_ready=0, and a 5th bundle is not written. Then out_accept=2 → count=6, in_ready=1 the following cycle.
- Wrap-around:
  - Stimulus: enqueue 3 bundles, drain 6, enqueue 2 more.
  - Response: entries at indices 6,7,0,1 come out in order with correct pcs, and count returns to 0.
- Delay-slot hold:
  - Stimulus: bundle {addiu, 0x10000003 beq} mask=11, then lanes drain so only beq remains in lane 0.
  - Response: out_valid=00 until the next bundle delivers its slot; then out_valid=11 with lane0=BEQ.
  - Second case: beq in lane 1 of the window with a following entry present gives out_valid=01.
- Flush collision:
  - Stimulus: count=5, with flush=1, in_valid=1 and out_accept=2 in the same cycle.
  - Response: next cycle count=0, out_valid=00, and the in_instr bundle is not stored.
- Reserved/reset:
  - Stimulus: enqueue 0xFC000000.
  - Response: out lane0 exception_ri=1, op=RESERVED.
  - Then assert resetn=0 mid-stream: count=0 and out_valid=0 after that edge.
